// File: rtl/gactx_bank3_example_axi_wr_ctrl_if.sv
// AW/B channel bundle between the write controller (master) and the AXI interconnect (slave).
// m_axi.bresp exists only when GACTX_WR_CTRL_BRESP_CHECK_EN is defined.
interface gactx_bank3_example_axi_wr_ctrl_if #(
  parameter int unsigned C_ADDR_WIDTH = 64
);
  logic                    awvalid;
  logic                    awready;
  logic [C_ADDR_WIDTH-1:0] awaddr;
  logic [7:0]              awlen;
  logic                    bvalid;
  logic                    bready;
`ifdef GACTX_WR_CTRL_BRESP_CHECK_EN
  logic [1:0]              bresp;

  modport master (
    output awvalid, awaddr, awlen, bready,
    input  awready, bvalid, bresp
  );

  modport slave (
    input  awvalid, awaddr, awlen, bready,
    output awready, bvalid, bresp
  );
`else
  modport master (
    output awvalid, awaddr, awlen, bready,
    input  awready, bvalid
  );

  modport slave (
    input  awvalid, awaddr, awlen, bready,
    output awready, bvalid
  );
`endif
endinterface

// File: rtl/gactx_bank3_example_axi_wr_ctrl.sv
// AXI4 write-side transaction controller: splits a transfer into fixed-length AW bursts under an
// outstanding-credit limit and retires B responses. Optional bresp checking: GACTX_WR_CTRL_BRESP_CHECK_EN.
module gactx_bank3_example_axi_wr_ctrl #(
  parameter int unsigned C_ADDR_WIDTH      = 64,
  parameter int unsigned C_XFER_SIZE_WIDTH = 32,
  parameter int unsigned C_DATA_WIDTH      = 512,
  parameter int unsigned C_BURST_LEN       = 64,
  parameter int unsigned C_MAX_OUTSTANDING = 16
) (
  input  logic                         aclk,
  input  logic                         areset,
  input  logic                         ctrl_start,
  input  logic [C_ADDR_WIDTH-1:0]      ctrl_addr_offset,
  input  logic [C_XFER_SIZE_WIDTH-1:0] ctrl_xfer_size_in_bytes,
  output logic                         ctrl_busy,
  output logic                         ctrl_done,
`ifdef GACTX_WR_CTRL_BRESP_CHECK_EN
  output logic                         ctrl_err,
`endif
  gactx_bank3_example_axi_wr_ctrl_if.master m_axi
);

  localparam int unsigned XS_W        = C_XFER_SIZE_WIDTH;
  localparam int unsigned BPB         = C_DATA_WIDTH / 8;
  localparam int unsigned BPB_LOG     = $clog2(BPB);
  localparam int unsigned BL_LOG      = $clog2(C_BURST_LEN);
  localparam int unsigned OUT_W       = $clog2(C_MAX_OUTSTANDING) + 1;
  localparam int unsigned BURST_BYTES = C_BURST_LEN * BPB;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                  state;
  logic [XS_W-1:0]         nbursts;
  logic [XS_W-1:0]         bursts_left;
  logic [XS_W-1:0]         retired;
  logic [OUT_W-1:0]        outstanding;
  logic [7:0]              last_len;
  logic                    awvalid_q;
  logic [C_ADDR_WIDTH-1:0] awaddr_q;
  logic [7:0]              awlen_q;
  logic                    bready_q;
  logic                    busy_q;
  logic                    done_q;

  // Transfer geometry derived from the start request.
  logic [XS_W-1:0] beats_c;
  logic [XS_W:0]   nb_sum_c;
  logic [XS_W-1:0] nbursts_c;
  logic [7:0]      last_len_c;
  logic [7:0]      first_len_c;

  assign beats_c     = ctrl_xfer_size_in_bytes >> BPB_LOG;
  assign nb_sum_c    = {1'b0, beats_c} + (XS_W+1)'(C_BURST_LEN - 1);
  assign nbursts_c   = XS_W'(nb_sum_c >> BL_LOG);
  assign last_len_c  = 8'((beats_c - XS_W'(1)) & XS_W'(C_BURST_LEN - 1));
  assign first_len_c = (nbursts_c == XS_W'(1)) ? last_len_c : 8'(C_BURST_LEN - 1);

  // Handshakes and next-cycle credit bookkeeping.
  logic             aw_hs_c;
  logic             b_hs_c;
  logic [OUT_W-1:0] out_nx_c;
  logic [XS_W-1:0]  retired_nx_c;
  logic             room_c;
  logic [7:0]       next_len_c;

  assign aw_hs_c      = awvalid_q & m_axi.awready;
  assign b_hs_c       = bready_q & m_axi.bvalid;
  assign out_nx_c     = outstanding + OUT_W'(aw_hs_c) - OUT_W'(b_hs_c);
  assign retired_nx_c = retired + XS_W'(b_hs_c);
  assign room_c       = (out_nx_c < OUT_W'(C_MAX_OUTSTANDING));
  assign next_len_c   = (bursts_left == XS_W'(2)) ? last_len : 8'(C_BURST_LEN - 1);

  always_ff @(posedge aclk) begin
    if (areset) begin
      state       <= IDLE;
      nbursts     <= '0;
      bursts_left <= '0;
      retired     <= '0;
      outstanding <= '0;
      last_len    <= '0;
      awvalid_q   <= 1'b0;
      awaddr_q    <= '0;
      awlen_q     <= '0;
      bready_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (ctrl_start) begin
            nbursts     <= nbursts_c;
            bursts_left <= nbursts_c;
            last_len    <= last_len_c;
            retired     <= '0;
            outstanding <= '0;
            awaddr_q    <= ctrl_addr_offset;
            awlen_q     <= first_len_c;
            busy_q      <= 1'b1;
            if (nbursts_c == '0) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              state     <= ISSUE;
              awvalid_q <= 1'b1;
              bready_q  <= 1'b1;
            end
          end
        end

        ISSUE: begin
          outstanding <= out_nx_c;
          retired     <= retired_nx_c;
          if (aw_hs_c) begin
            bursts_left <= bursts_left - XS_W'(1);
            awaddr_q    <= awaddr_q + C_ADDR_WIDTH'(BURST_BYTES);
            awlen_q     <= next_len_c;
          end
          // A stalled AW keeps awvalid high: credit can only have been returned since it rose.
          if (aw_hs_c && (bursts_left == XS_W'(1))) begin
            state     <= DRAIN;
            awvalid_q <= 1'b0;
          end else begin
            awvalid_q <= room_c;
          end
        end

        DRAIN: begin
          outstanding <= out_nx_c;
          retired     <= retired_nx_c;
          if (retired_nx_c == nbursts) begin
            state    <= DONE;
            done_q   <= 1'b1;
            bready_q <= 1'b0;
          end
        end

        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifdef GACTX_WR_CTRL_BRESP_CHECK_EN
  // Sticky error on any non-OKAY retired response; cleared by the next accepted start.
  logic err_q;

  always_ff @(posedge aclk) begin
    if (areset) begin
      err_q <= 1'b0;
    end else if ((state == IDLE) && ctrl_start) begin
      err_q <= 1'b0;
    end else if (b_hs_c && (m_axi.bresp != 2'b00)) begin
      err_q <= 1'b1;
    end
  end

  assign ctrl_err = err_q;
`endif

  assign ctrl_busy     = busy_q;
  assign ctrl_done     = done_q;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.awaddr  = awaddr_q;
  assign m_axi.awlen   = awlen_q;
  assign m_axi.bready  = bready_q;

endmodule

// File: tb/tb_gactx_bank3_example_axi_wr_ctrl.sv
// Bench for gactx_bank3_example_axi_wr_ctrl: transfer-level model checked every cycle, B responder
// with programmable credit, plus literal expectations. Honors GACTX_WR_CTRL_BRESP_CHECK_EN.
module tb_gactx_bank3_example_axi_wr_ctrl;

  localparam int B_DELAY = 4;
  localparam int MAXO    = 16;

  logic        clk;
  logic        rst;
  logic        start;
  logic [63:0] addr;
  logic [31:0] size;
  logic        busy;
  logic        done;
`ifdef GACTX_WR_CTRL_BRESP_CHECK_EN
  logic        err;
  int          bad_idx;
`endif

  gactx_bank3_example_axi_wr_ctrl_if #(.C_ADDR_WIDTH(64)) m_axi ();

  gactx_bank3_example_axi_wr_ctrl dut (
    .aclk                    (clk),
    .areset                  (rst),
    .ctrl_start              (start),
    .ctrl_addr_offset        (addr),
    .ctrl_xfer_size_in_bytes (size),
    .ctrl_busy               (busy),
    .ctrl_done               (done),
`ifdef GACTX_WR_CTRL_BRESP_CHECK_EN
    .ctrl_err                (err),
`endif
    .m_axi                   (m_axi)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Responder credit: B responses are only issued while b_sent < b_allow.
  int b_allow = 0;
  int b_sent  = 0;

  // Model state and logs.
  int          phase = 0;  // 0 idle, 1 running, 2 done cycle
  logic [63:0] m_base;
  int          m_nb, m_last, m_issued, m_retired, m_out;
  bit          m_err;
  logic [63:0] aw_addr[$];
  int          aw_len[$];
  int          aw_cyc[$];
  int          done_cnt = 0;
  int          last_done_cyc = 0, last_b_cyc = 0, start_cyc = 0, busy_cnt = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Per-cycle compare against the transfer-level model, then advance the model.
  initial begin : monitor
    bit exp_awv;
    int exp_len;
    @(posedge clk);
    forever begin
      @(negedge clk);
      exp_awv = (phase == 1) && (m_issued < m_nb) && (m_out < MAXO);
      chk("busy",    64'(busy),          64'(phase != 0));
      chk("done",    64'(done),          64'(phase == 2));
      chk("bready",  64'(m_axi.bready),  64'(phase == 1));
      chk("awvalid", 64'(m_axi.awvalid), 64'(exp_awv));
      if (exp_awv && m_axi.awvalid) begin
        exp_len = (m_issued == m_nb - 1) ? m_last : 63;
        chk("awaddr", m_axi.awaddr, m_base + 64'(m_issued) * 64'h1000);
        chk("awlen",  64'(m_axi.awlen), 64'(exp_len));
      end
`ifdef GACTX_WR_CTRL_BRESP_CHECK_EN
      chk("ctrl_err", 64'(err), 64'(m_err));
`endif
      if (rst) begin
        phase = 0;
        m_out = 0;
        m_err = 1'b0;
      end else begin
        if (busy) busy_cnt++;
        if (done) begin
          done_cnt++;
          last_done_cyc = cyc;
        end
        if (m_axi.awvalid && m_axi.awready) begin
          aw_addr.push_back(m_axi.awaddr);
          aw_len.push_back(int'(m_axi.awlen));
          aw_cyc.push_back(cyc);
          m_issued++;
          m_out++;
        end
        if (m_axi.bvalid && m_axi.bready) begin
          m_retired++;
          m_out--;
          last_b_cyc = cyc;
`ifdef GACTX_WR_CTRL_BRESP_CHECK_EN
          if (m_axi.bresp != 2'b00) m_err = 1'b1;
`endif
        end
        case (phase)
          0: if (start) begin
            m_base    = addr;
            m_nb      = (int'(size / 64) + 63) / 64;
            m_last    = (size == 0) ? 0 : (int'(size / 64) - 1) % 64;
            m_issued  = 0;
            m_retired = 0;
            m_out     = 0;
            m_err     = 1'b0;
            busy_cnt  = 0;
            start_cyc = cyc;
            phase     = (m_nb == 0) ? 2 : 1;
          end
          1: if (m_retired == m_nb) phase = 2;
          default: phase = 0;
        endcase
      end
    end
  end

  // B responder: one response per issued AW, B_DELAY cycles later, gated by b_allow.
  initial begin : responder
    int pend[$];
    bit bv_n;
    m_axi.bvalid = 1'b0;
`ifdef GACTX_WR_CTRL_BRESP_CHECK_EN
    m_axi.bresp = 2'b00;
`endif
    forever begin
      @(negedge clk);
      if (rst) begin
        pend.delete();
        bv_n = 1'b0;
      end else begin
        if (m_axi.bvalid && m_axi.bready) begin
          void'(pend.pop_front());
          b_sent++;
        end
        if (m_axi.awvalid && m_axi.awready) pend.push_back(cyc);
        bv_n = (pend.size() > 0) && (cyc + 1 >= pend[0] + B_DELAY) && (b_sent < b_allow);
      end
      @(posedge clk);
      #1;
      m_axi.bvalid = bv_n;
`ifdef GACTX_WR_CTRL_BRESP_CHECK_EN
      m_axi.bresp = (b_sent == bad_idx) ? 2'b10 : 2'b00;
`endif
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [63:0] a, input logic [31:0] s);
    sync();
    start = 1'b1;
    addr  = a;
    size  = s;
    sync();
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget, input string nm);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done_cnt != d0) begin
        seen = 1'b1;
        break;
      end
    end
    chk(nm, 64'(seen), 64'd1);
  endtask

  task automatic chk_aw(input string nm, input int idx, input logic [63:0] a, input int l);
    chk({nm, "_addr"}, aw_addr[idx], a);
    chk({nm, "_len"}, 64'(aw_len[idx]), 64'(l));
  endtask

  initial begin : stim
    int d0, a0;
    rst   = 1'b1;
    start = 1'b0;
    addr  = '0;
    size  = '0;
    m_axi.awready = 1'b0;
`ifdef GACTX_WR_CTRL_BRESP_CHECK_EN
    bad_idx = -1;
`endif
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    sync();
    m_axi.awready = 1'b1;
    b_allow = 1000000;

    // Zero-byte transfer: no AW, one busy cycle, done right after.
    d0 = done_cnt; a0 = aw_addr.size();
    do_start(64'h0, 32'd0);
    wait_done(d0, 10, "sz0_done_seen");
    chk("sz0_latency", 64'(last_done_cyc - start_cyc), 64'd1);
    chk("sz0_busy_cycles", 64'(busy_cnt), 64'd1);
    chk("sz0_no_aw", 64'(aw_addr.size() - a0), 64'd0);

    // 192 beats: three full bursts.
    d0 = done_cnt; a0 = aw_addr.size();
    do_start(64'h0, 32'd12288);
    wait_done(d0, 200, "t2_done_seen");
    repeat (4) tick();
    chk("t2_aw_count", 64'(aw_addr.size() - a0), 64'd3);
    chk_aw("t2_b0", a0 + 0, 64'h0000, 63);
    chk_aw("t2_b1", a0 + 1, 64'h1000, 63);
    chk_aw("t2_b2", a0 + 2, 64'h2000, 63);
    chk("t2_one_done", 64'(done_cnt - d0), 64'd1);
    chk("t2_done_after_b", 64'(last_done_cyc - last_b_cyc), 64'd1);

    // 130 beats: remainder burst of 2 beats.
    d0 = done_cnt; a0 = aw_addr.size();
    do_start(64'h10000, 32'd8320);
    wait_done(d0, 200, "t3_done_seen");
    chk("t3_aw_count", 64'(aw_addr.size() - a0), 64'd3);
    chk_aw("t3_b0", a0 + 0, 64'h10000, 63);
    chk_aw("t3_b1", a0 + 1, 64'h11000, 63);
    chk_aw("t3_b2", a0 + 2, 64'h12000, 1);
    chk("t3_done_after_b", 64'(last_done_cyc - last_b_cyc), 64'd1);

    // Single beat: awlen 0.
    d0 = done_cnt; a0 = aw_addr.size();
    do_start(64'h20000, 32'd64);
    wait_done(d0, 50, "t1b_done_seen");
    chk("t1b_aw_count", 64'(aw_addr.size() - a0), 64'd1);
    chk_aw("t1b_b0", a0, 64'h20000, 0);

    // 20 bursts with no responses: credit limit stops AW at 16.
    d0 = done_cnt; a0 = aw_addr.size();
    b_allow = b_sent;
    do_start(64'h100000, 32'd81920);
    repeat (30) tick();
    chk("full_aw_count", 64'(aw_addr.size() - a0), 64'd16);
    chk("full_awvalid_low", 64'(m_axi.awvalid), 64'd0);
    b_allow = b_sent + 1;
    for (int i = 0; i < 12 && aw_addr.size() < a0 + 17; i++) tick();
    chk("full_17th_count", 64'(aw_addr.size() - a0), 64'd17);
    chk("full_17th_next_cycle", 64'(aw_cyc[a0 + 16] - last_b_cyc), 64'd1);
    b_allow = b_sent + 2;
    repeat (10) tick();
    chk("full_19_count", 64'(aw_addr.size() - a0), 64'd19);
    chk("full_same_cycle_hs", 64'(aw_cyc[a0 + 17]), 64'(last_b_cyc));
    chk("full_out_16", 64'(m_out), 64'd16);

    // Stall awready with the 20th burst pending while all responses drain.
    sync();
    m_axi.awready = 1'b0;
    b_allow = 1000000;
    repeat (30) tick();
    chk("stall_awvalid_held", 64'(m_axi.awvalid), 64'd1);
    chk("stall_awaddr", m_axi.awaddr, 64'h113000);
    chk("stall_awlen", 64'(m_axi.awlen), 64'd63);
    chk("stall_out_0", 64'(m_out), 64'd0);
    sync();
    m_axi.awready = 1'b1;
    wait_done(d0, 50, "stall_done_seen");
    chk("stall_aw_count", 64'(aw_addr.size() - a0), 64'd20);

    // Reset while draining five outstanding bursts, then a clean transfer.
    a0 = aw_addr.size();
    b_allow = b_sent;
    do_start(64'h200000, 32'd20480);
    repeat (10) tick();
    chk("rst_aw_count", 64'(aw_addr.size() - a0), 64'd5);
    chk("rst_busy_before", 64'(busy), 64'd1);
    sync();
    rst = 1'b1;
    repeat (2) tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_awvalid", 64'(m_axi.awvalid), 64'd0);
    chk("rst_bready", 64'(m_axi.bready), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    sync();
    rst = 1'b0;
    b_allow = 1000000;
    d0 = done_cnt; a0 = aw_addr.size();
    do_start(64'h300000, 32'd8192);
    wait_done(d0, 100, "post_rst_done_seen");
    chk("post_rst_aw_count", 64'(aw_addr.size() - a0), 64'd2);
    chk_aw("post_rst_b0", a0 + 0, 64'h300000, 63);
    chk_aw("post_rst_b1", a0 + 1, 64'h301000, 63);

`ifdef GACTX_WR_CTRL_BRESP_CHECK_EN
    // SLVERR on the second response: sticky through done, cleared by the next start.
    d0 = done_cnt;
    bad_idx = b_sent + 1;
    do_start(64'h400000, 32'd12288);
    wait_done(d0, 200, "err_done_seen");
    chk("err_at_done", 64'(err), 64'd1);
    repeat (3) tick();
    chk("err_sticky_idle", 64'(err), 64'd1);
    bad_idx = -1;
    d0 = done_cnt;
    do_start(64'h0, 32'd4096);
    chk("err_cleared_by_start", 64'(err), 64'd0);
    wait_done(d0, 100, "err2_done_seen");
    chk("err_clean_run", 64'(err), 64'd0);
`endif

    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
